// File: rtl/advanced_timer_v3_pkg.sv
// Shared definitions for advanced_timer_v3: state encoding and parameter defaults.
package adv_timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        SEARCH   = 2'd0,
        SHIFT    = 2'd1,
        COUNT    = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    localparam int         DEF_PAT_W   = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1101;
    localparam int         DEF_DELAY_W = 4;
    localparam int         DEF_TICK    = 1000;

endpackage

// File: rtl/advanced_timer_v3_if.sv
// Bus between the timer and its user: serial data, ack and abort in; status out.
interface advanced_timer_v3_if
    import adv_timer_pkg::*;
#(
    parameter int DELAY_W = DEF_DELAY_W
);
    logic               data;
    logic               ack;
    logic               abort;
    logic               counting;
    logic               done;
    logic [DELAY_W-1:0] remaining;

    modport master (output data, ack, abort, input counting, done, remaining);
    modport slave  (input data, ack, abort, output counting, done, remaining);
endinterface

// File: rtl/advanced_timer_v3_pattern_detect.sv
// Serial start-pattern detector with overlapping matches and a synchronous clear.
// The stored history holds the PAT_W-1 previous bits; together with the bit on
// the input this forms the PAT_W-bit window compared against PATTERN.
// A fill counter stops the zeroed history from contributing to a false match.
module pattern_detect
    import adv_timer_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic data,
    output logic match
);
    localparam int                HIST_W = PAT_W - 1;
    localparam int                FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] PRIOR  = FILL_W'(PAT_W - 1);

    logic [HIST_W-1:0] history;
    logic [FILL_W-1:0] fill;

    // Shift the incoming bit into the history and count bits since the last clear.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            history <= '0;
            fill    <= '0;
        end else begin
            history <= HIST_W'({history, data});
            if (fill != PRIOR) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    // A match needs a full window of genuinely received bits.
    always_comb begin
        match = (fill == PRIOR) && ({history, data} == PATTERN);
    end
endmodule

// File: rtl/advanced_timer_v3.sv
// Pattern-triggered delay timer: waits for PATTERN on the serial input, reads a
// DELAY_W-bit delay, counts (delay+1)*TICK cycles, then holds done until ack.
// Optional feature macro: ADV_TIMER_ABORT_EN enables the abort input.
module advanced_timer_v3
    import adv_timer_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int               DELAY_W = DEF_DELAY_W,
    parameter int               TICK    = DEF_TICK
) (
    input logic                clk,
    input logic                reset,
    advanced_timer_v3_if.slave bus
);
    localparam int                 TICK_W    = $clog2(TICK);
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK - 1);
    localparam int                 BIT_W     = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;
    localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(DELAY_W - 1);

    state_t             state, state_next;
    logic [DELAY_W-1:0] delay_reg, delay_next;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_next;
    logic [TICK_W-1:0]  tick_cnt, tick_next;
    logic [DELAY_W-1:0] remaining_q, remaining_next;
    logic               counting_q, counting_next;
    logic               done_q, done_next;
    logic               match;
    logic [DELAY_W-1:0] delay_shifted;

    pattern_detect #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_detect (
        .clk   (clk),
        .reset (reset),
        .clear (state != SEARCH),
        .data  (bus.data),
        .match (match)
    );

`ifndef ADV_TIMER_ABORT_EN
    logic unused_abort;
    assign unused_abort = bus.abort;
`endif

    assign delay_shifted = DELAY_W'({delay_reg, bus.data});

    // State and all registered outputs; reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= SEARCH;
            delay_reg   <= '0;
            bit_cnt     <= '0;
            tick_cnt    <= '0;
            remaining_q <= '0;
            counting_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_next;
            delay_reg   <= delay_next;
            bit_cnt     <= bit_cnt_next;
            tick_cnt    <= tick_next;
            remaining_q <= remaining_next;
            counting_q  <= counting_next;
            done_q      <= done_next;
        end
    end

    // Next-state logic; remaining doubles as the unit down-counter so the
    // all-ones delay needs no wider counter.
    always_comb begin
        state_next     = state;
        delay_next     = delay_reg;
        bit_cnt_next   = bit_cnt;
        tick_next      = tick_cnt;
        remaining_next = remaining_q;
        counting_next  = counting_q;
        done_next      = done_q;

        case (state)
            SEARCH: begin
                bit_cnt_next = '0;
                if (match) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                delay_next = delay_shifted;
                if (bit_cnt == BIT_LAST) begin
                    state_next     = COUNT;
                    bit_cnt_next   = '0;
                    tick_next      = '0;
                    remaining_next = delay_shifted;
                    counting_next  = 1'b1;
                end else begin
                    bit_cnt_next = bit_cnt + BIT_W'(1);
                end
            end
            COUNT: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_next = '0;
                    if (remaining_q == '0) begin
                        state_next    = WAIT_ACK;
                        counting_next = 1'b0;
                        done_next     = 1'b1;
                    end else begin
                        remaining_next = remaining_q - DELAY_W'(1);
                    end
                end else begin
                    tick_next = tick_cnt + TICK_W'(1);
                end
            end
            WAIT_ACK: begin
                if (bus.ack) begin
                    state_next = SEARCH;
                    done_next  = 1'b0;
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase

`ifdef ADV_TIMER_ABORT_EN
        if (bus.abort && (state == SHIFT || state == COUNT)) begin
            state_next     = SEARCH;
            bit_cnt_next   = '0;
            tick_next      = '0;
            remaining_next = '0;
            counting_next  = 1'b0;
            done_next      = 1'b0;
        end
`endif
    end

    assign bus.counting  = counting_q;
    assign bus.done      = done_q;
    assign bus.remaining = remaining_q;
endmodule
